lbp_engine: RTL and testbench
=============================

# lbp_engine

Parametrised local-binary-pattern engine for W×H grayscale frames held in a single-port gray RAM. It reads each pixel exactly once in raster order, keeps a 3×3 window using two on-chip line buffers, and writes one LBP code per pixel into the LBP RAM. Border pixels are written as 0. It is the frame-size-generic successor to the fixed 64×64 LBP block and uses the same RAM handshake, so existing benches and RAM models connect unchanged.

## Interface
- IMG_W, 64, frame width in pixels; minimum 3.
- IMG_H, 64, frame height in pixels; minimum 3.
- DATAWIDTH, 8, pixel and LBP code width; the code uses 8 bits, zero-extended if DATAWIDTH > 8.
- ADDRWIDTH, 12, RAM address width; requires 2^ADDRWIDTH ≥ IMG_W·IMG_H.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  start request; a 0→1 transition sampled in IDLE starts a frame.
- gray_addr  out  ADDRWIDTH  gray RAM read address.
- gray_OE  out  1  gray RAM read enable.
- gray_data  in  DATAWIDTH  gray RAM read data, valid one cycle after the address/OE cycle.
- lbp_addr  out  ADDRWIDTH  LBP RAM write address.
- lbp_WEN  out  1  LBP RAM write enable, active high; one word per cycle.
- lbp_data  out  DATAWIDTH  LBP RAM write data.
- finish  out  1  one-cycle pulse after the final write of a frame.
- busy  out  1  high from the start cycle through the finish cycle.
- thresh  in  DATAWIDTH  comparison offset; present only with LBP_THRESH_EN.

## Operation
- **States:** IDLE → STREAM → DRAIN → BORDER → DONE → IDLE.
- **IDLE:** all outputs are 0. The block moves to STREAM when enable is high and enable was low in the previous cycle. Enable held high never retriggers a frame.
- **STREAM:** issues reads at addresses 0 … IMG_W·IMG_H−1, one per cycle, with gray_OE=1. Address = r·IMG_W + c.
- **Window:** returned data shifts into two line buffers of IMG_W−1 … IMG_W entries each and into a 3×3 register window.
- **Interior results:** when the pixel returned is (r,c) with r ≥ 2 and c ≥ 2, the block writes the code for centre (r−1,c−1) to address (r−1)·IMG_W + (c−1).
- **DRAIN:** waits for the last read and the last write to complete, then enters BORDER.
- **LBP code:** neighbour bits are ordered bit0 = (−1,−1), bit1 = (−1,0), bit2 = (−1,+1), bit3 = (0,−1), bit4 = (0,+1), bit5 = (+1,−1), bit6 = (+1,0), bit7 = (+1,+1). Each bit = (neighbour ≥ centre), unsigned compare.
- **BORDER:** writes 0 to every border address, one per cycle, in this order:
  - row 0, left to right;
  - for r = 1 … IMG_H−2: column 0, then column IMG_W−1;
  - row IMG_H−1, left to right.
  - Total border writes = 2·IMG_W + 2·IMG_H − 4.
- **DONE:** finish=1 for one cycle, then IDLE. LBP RAM contents outside the frame are never written.
- **Enable mid-frame:** ignored.
- **Reset mid-frame:** reset takes effect immediately. The block returns to IDLE, deasserts all outputs and clears the window and counters. Partial LBP RAM contents are left as written; a new frame needs a fresh enable edge.

## Timing
- **Reset values:** gray_addr=0, gray_OE=0, lbp_addr=0, lbp_WEN=0, lbp_data=0, finish=0, busy=0.
- **Start:** the first read (address 0) is issued the cycle after the enable edge is sampled.
- **Read latency:** a read issued in cycle t returns data that is registered at the end of cycle t+1.
- **Write latency:** the write for that pixel is driven during cycle t+2; lbp_addr, lbp_data and lbp_WEN are all registered.
- **Throughput:** one read per cycle with no stalls in STREAM; one write per cycle in BORDER.
- **Frame length:** start edge to finish = IMG_W·IMG_H + 2 + (2·IMG_W + 2·IMG_H − 4) + 1 cycles, ±1 for the DRAIN handoff. This is fixed for given parameters.

## Configuration
- **LBP_THRESH_EN defined:** port thresh exists. Bit = (neighbour ≥ centre + thresh), with the sum computed in DATAWIDTH+1 bits; if the sum overflows, the bit is 0.
- **LBP_THRESH_EN undefined:** no thresh port; behaviour is identical to thresh = 0.

## Test plan
- 64×64 pattern.dat, enable high for 3 cycles → all 4096 LBP RAM words equal golden.dat; finish pulses once; busy falls with finish.
- IMG_W=5, IMG_H=4, constant image 0x80 → interior addresses 6, 7, 8, 11, 12, 13 = 0xFF; all 14 border addresses = 0x00; exactly 20 writes.
- IMG_W=3, IMG_H=3, pixels 0x10…0x90 row-major → address 4 = 0xF0 (bits 4–7 set); the 8 border words = 0.
- rst asserted low at cycle 500 of a 64×64 frame → all outputs 0 in the same cycle; no writes until a new enable edge; the rerun then matches golden.
- enable held high through and after a frame → exactly one frame runs; no second finish within 20000 cycles.
- LBP_THRESH_EN, thresh=0x10, centre 0x80 with neighbours 0x8F/0x90 alternating → bits set only where the neighbour is 0x90; thresh=0xFF with centre 0x01 → code 0x00.

Source files
------------

// File: rtl/lbp_engine.sv
// lbp_engine: streaming 3x3 local-binary-pattern engine for IMG_W x IMG_H frames.
// Reads every gray pixel once in raster order, keeps a 3x3 window via two line
// buffers, writes one LBP code per interior pixel and 0 for every border pixel.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   enable           start request (0->1 edge sampled in IDLE starts a frame)
//   gray_addr/OE     gray RAM read address / read enable
//   gray_data        gray RAM read data (one cycle after address/OE)
//   lbp_addr/WEN/data  LBP RAM write port (active-high write enable)
//   finish           one-cycle pulse after the last write of a frame
//   busy             high from the first read cycle through the finish cycle
//   thresh           comparison offset, only present with LBP_THRESH_EN
//
// Optional feature macro: LBP_THRESH_EN (adds the thresh port).
module lbp_engine #(
  parameter int unsigned IMG_W     = 64,
  parameter int unsigned IMG_H     = 64,
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ADDRWIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic [ADDRWIDTH-1:0] gray_addr,
  output logic                 gray_OE,
  input  logic [DATAWIDTH-1:0] gray_data,
  output logic [ADDRWIDTH-1:0] lbp_addr,
  output logic                 lbp_WEN,
  output logic [DATAWIDTH-1:0] lbp_data,
  output logic                 finish,
  output logic                 busy
`ifdef LBP_THRESH_EN
  ,
  input  logic [DATAWIDTH-1:0] thresh
`endif
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned DW = DATAWIDTH;
  localparam int unsigned AW = ADDRWIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_BORDER,
    S_DONE
  } state_t;

  state_t state;
  logic   en_q;

  // coordinates of the read currently on gray_addr
  logic [CW-1:0] rd_c;
  logic [RW-1:0] rd_r;

  // coordinates/address of the pixel arriving on gray_data this cycle
  logic          ret_valid;
  logic [CW-1:0] ret_c;
  logic [RW-1:0] ret_r;
  logic [AW-1:0] ret_addr;

  // window columns: *0 = column c-2, *1 = column c-1; rows top/mid/bot
  logic [DW-1:0] w00, w01, w10, w11, w20, w21;
  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] up_new, mid_new;

  // border walk
  logic [CW-1:0] b_c;
  logic [RW-1:0] b_r;
  logic [AW-1:0] b_addr;

  logic [DW-1:0] th;
  logic [DW:0]   ref_v;
  logic [7:0]    code_c;
  logic          rd_last, b_last, int_wr;

`ifdef LBP_THRESH_EN
  assign th = thresh;
`else
  assign th = '0;
`endif

  // lb1 holds row r-2, lb0 holds row r-1 at the column being returned
  assign up_new  = lb1[ret_c];
  assign mid_new = lb0[ret_c];

  assign rd_last = (rd_r == RW'(IMG_H - 1)) && (rd_c == CW'(IMG_W - 1));
  assign b_last  = (b_r == RW'(IMG_H - 1)) && (b_c == CW'(IMG_W - 1));
  assign int_wr  = ret_valid && (ret_r >= RW'(2)) && (ret_c >= CW'(2));

  // LBP code for centre w11; sum kept one bit wider so an overflowing
  // reference can never be reached by any neighbour
  always_comb begin
    ref_v     = (DW+1)'(w11) + (DW+1)'(th);
    code_c    = '0;
    code_c[0] = (DW+1)'(w00)       >= ref_v;
    code_c[1] = (DW+1)'(w01)       >= ref_v;
    code_c[2] = (DW+1)'(up_new)    >= ref_v;
    code_c[3] = (DW+1)'(w10)       >= ref_v;
    code_c[4] = (DW+1)'(mid_new)   >= ref_v;
    code_c[5] = (DW+1)'(w20)       >= ref_v;
    code_c[6] = (DW+1)'(w21)       >= ref_v;
    code_c[7] = (DW+1)'(gray_data) >= ref_v;
  end

  // line buffers need no reset: rows are always refilled before they are used
  always_ff @(posedge clk) begin
    if (ret_valid) begin
      lb1[ret_c] <= lb0[ret_c];
      lb0[ret_c] <= gray_data;
    end
  end

  // read-return pipeline and 3x3 window shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_valid <= 1'b0;
      ret_c     <= '0;
      ret_r     <= '0;
      ret_addr  <= '0;
      w00 <= '0; w01 <= '0;
      w10 <= '0; w11 <= '0;
      w20 <= '0; w21 <= '0;
    end else begin
      ret_valid <= gray_OE;
      ret_c     <= rd_c;
      ret_r     <= rd_r;
      ret_addr  <= gray_addr;
      if (ret_valid) begin
        w00 <= w01; w01 <= up_new;
        w10 <= w11; w11 <= mid_new;
        w20 <= w21; w21 <= gray_data;
      end
    end
  end

  // frame control FSM with registered RAM-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      en_q      <= 1'b1;  // enable held high across reset must not look like an edge
      gray_addr <= '0;
      gray_OE   <= 1'b0;
      lbp_addr  <= '0;
      lbp_WEN   <= 1'b0;
      lbp_data  <= '0;
      finish    <= 1'b0;
      busy      <= 1'b0;
      rd_c      <= '0;
      rd_r      <= '0;
      b_c       <= '0;
      b_r       <= '0;
      b_addr    <= '0;
    end else begin
      en_q     <= enable;
      finish   <= 1'b0;
      lbp_WEN  <= 1'b0;
      lbp_addr <= '0;
      lbp_data <= '0;

      // interior write for centre (r-1,c-1) one cycle after pixel (r,c) returns
      if (int_wr) begin
        lbp_WEN  <= 1'b1;
        lbp_addr <= ret_addr - AW'(IMG_W + 1);
        lbp_data <= DW'(code_c);
      end

      case (state)
        S_IDLE: begin
          busy      <= 1'b0;
          gray_OE   <= 1'b0;
          gray_addr <= '0;
          if (enable && !en_q) begin
            state   <= S_STREAM;
            busy    <= 1'b1;
            gray_OE <= 1'b1;
            rd_c    <= '0;
            rd_r    <= '0;
          end
        end

        S_STREAM: begin
          if (rd_last) begin
            gray_OE   <= 1'b0;
            gray_addr <= '0;
            rd_c      <= '0;
            rd_r      <= '0;
            state     <= S_DRAIN;
          end else begin
            gray_addr <= gray_addr + AW'(1);
            if (rd_c == CW'(IMG_W - 1)) begin
              rd_c <= '0;
              rd_r <= rd_r + RW'(1);
            end else begin
              rd_c <= rd_c + CW'(1);
            end
          end
        end

        // last pixel returns here; its write is registered at this edge
        S_DRAIN: begin
          b_c    <= '0;
          b_r    <= '0;
          b_addr <= '0;
          state  <= S_BORDER;
        end

        // top row, then left/right pairs, then bottom row
        S_BORDER: begin
          lbp_WEN  <= 1'b1;
          lbp_addr <= b_addr;
          lbp_data <= '0;
          if (b_last) begin
            state <= S_DONE;
          end else if ((b_r == '0) || (b_r == RW'(IMG_H - 1))) begin
            b_addr <= b_addr + AW'(1);
            if (b_c == CW'(IMG_W - 1)) begin
              b_c <= '0;
              b_r <= b_r + RW'(1);
            end else begin
              b_c <= b_c + CW'(1);
            end
          end else if (b_c == '0) begin
            b_c    <= CW'(IMG_W - 1);
            b_addr <= b_addr + AW'(IMG_W - 1);
          end else begin
            b_c    <= '0;
            b_r    <= b_r + RW'(1);
            b_addr <= b_addr + AW'(1);
          end
        end

        S_DONE: begin
          finish <= 1'b1;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_engine.sv
// Self-checking bench for lbp_engine on a 5x4 frame: a gray RAM model, an LBP
// RAM model, a cycle schedule built from the frame rules, and one compare
// process checking every output cycle of each frame.
module tb_lbp_engine;

  localparam int W     = 5;
  localparam int H     = 4;
  localparam int N     = W * H;
  localparam int B     = 2 * W + 2 * H - 4;
  localparam int FIN   = N + 3 + B;
  localparam int LAST  = FIN + 4;
  localparam int MAXC  = 64;
  localparam int MEMSZ = 32;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [11:0] gray_addr;
  logic        gray_OE;
  logic [7:0]  gray_data;
  logic [11:0] lbp_addr;
  logic        lbp_WEN;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        busy;
`ifdef LBP_THRESH_EN
  logic [7:0]  thresh;
`endif

  lbp_engine #(
    .IMG_W(W), .IMG_H(H), .DATAWIDTH(8), .ADDRWIDTH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .gray_addr(gray_addr),
    .gray_OE(gray_OE),
    .gray_data(gray_data),
    .lbp_addr(lbp_addr),
    .lbp_WEN(lbp_WEN),
    .lbp_data(lbp_data),
    .finish(finish),
    .busy(busy)
`ifdef LBP_THRESH_EN
    ,
    .thresh(thresh)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests;
  int n_fail;
  int th_val;
  int cyc;
  logic chk_on;
  logic clr_mem;

  logic [7:0] img     [N];
  logic [7:0] lbp_mem [MEMSZ];
  int         wr_cnt;
  int         exp_mem [N];

  int e_oe    [MAXC];
  int e_raddr [MAXC];
  int e_wen   [MAXC];
  int e_waddr [MAXC];
  int e_wdata [MAXC];
  int e_fin   [MAXC];
  int e_busy  [MAXC];

  // gray RAM: data for the address seen in cycle t appears in cycle t+1
  always @(posedge clk) begin
    if (gray_OE) begin
      if (int'(gray_addr) < N) gray_data <= img[int'(gray_addr)];
      else                     gray_data <= 8'h00;
    end
  end

  // LBP RAM with write counter; clr_mem refills it with a sentinel
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < MEMSZ; i++) lbp_mem[i] <= 8'hAA;
      wr_cnt <= 0;
    end else if (lbp_WEN) begin
      if (int'(lbp_addr) < MEMSZ) lbp_mem[int'(lbp_addr)] <= lbp_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp_v, input int where);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at=%0d actual=0x%0h expected=0x%0h", name, where, act, exp_v);
    end
  endtask

  // LBP code straight from the neighbour ordering and the >= (centre+thresh) rule
  function automatic int model_code(input int r, input int c);
    int dr [8];
    int dc [8];
    int refv;
    int code;
    dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
    dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
    refv = int'(img[r * W + c]) + th_val;
    code = 0;
    for (int i = 0; i < 8; i++)
      if (int'(img[(r + dr[i]) * W + (c + dc[i])]) >= refv) code |= (1 << i);
    return code;
  endfunction

  // per-cycle schedule; cycle 0 is the cycle whose end samples the enable edge
  task automatic build_expected();
    int bq [$];
    int r, c, j;
    for (int i = 0; i < MAXC; i++) begin
      e_oe[i] = 0; e_raddr[i] = 0; e_wen[i] = 0; e_waddr[i] = 0;
      e_wdata[i] = 0; e_fin[i] = 0; e_busy[i] = 0;
    end
    for (int k = 0; k < N; k++) begin
      r = k / W;
      c = k % W;
      e_oe[k + 1]    = 1;
      e_raddr[k + 1] = k;
      if (r >= 2 && c >= 2) begin
        e_wen[k + 3]   = 1;
        e_waddr[k + 3] = (r - 1) * W + (c - 1);
        e_wdata[k + 3] = model_code(r - 1, c - 1);
        exp_mem[(r - 1) * W + (c - 1)] = e_wdata[k + 3];
      end
    end
    for (int cc = 0; cc < W; cc++) bq.push_back(cc);
    for (int rr = 1; rr <= H - 2; rr++) begin
      bq.push_back(rr * W);
      bq.push_back(rr * W + W - 1);
    end
    for (int cc = 0; cc < W; cc++) bq.push_back((H - 1) * W + cc);
    j = 0;
    foreach (bq[q]) begin
      e_wen[N + 3 + j]   = 1;
      e_waddr[N + 3 + j] = bq[q];
      e_wdata[N + 3 + j] = 0;
      exp_mem[bq[q]]     = 0;
      j++;
    end
    e_fin[FIN] = 1;
    for (int cc = 1; cc <= FIN; cc++) e_busy[cc] = 1;
  endtask

  // single compare process: every cycle of a frame, #1 after the rising edge
  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      if (chk_on) begin
        cyc = cyc + 1;
        chk("gray_OE", int'(gray_OE), e_oe[cyc], cyc);
        if (e_oe[cyc] != 0) chk("gray_addr", int'(gray_addr), e_raddr[cyc], cyc);
        chk("lbp_WEN", int'(lbp_WEN), e_wen[cyc], cyc);
        if (e_wen[cyc] != 0) begin
          chk("lbp_addr", int'(lbp_addr), e_waddr[cyc], cyc);
          chk("lbp_data", int'(lbp_data), e_wdata[cyc], cyc);
        end
        chk("finish", int'(finish), e_fin[cyc], cyc);
        chk("busy", int'(busy), e_busy[cyc], cyc);
        if (cyc >= LAST) chk_on = 1'b0;
      end
    end
  end

  task automatic clear_mem();
    @(negedge clk);
    clr_mem = 1'b1;
    @(negedge clk);
    clr_mem = 1'b0;
  endtask

  // hold: loop index at which enable drops (-1 keeps it high);
  // tog: loop index at which a mid-frame enable edge is made (-1 for none)
  task automatic run_frame(input int hold, input int tog);
    build_expected();
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    cyc    = 0;
    chk_on = 1'b1;
    for (int i = 0; i < LAST + 10 && chk_on; i++) begin
      @(negedge clk);
      if (i == hold) enable = 1'b0;
      if (i == tog) enable = 1'b0;
      if (i == tog + 1) enable = 1'b1;
      if (i == tog + 3 && hold >= 0) enable = 1'b0;
    end
    if (chk_on) begin
      chk("frame_timeout", 1, 0, cyc);
      chk_on = 1'b0;
    end
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < N; a++) chk({tag, "_mem"}, int'(lbp_mem[a]), exp_mem[a], a);
    for (int a = N; a < MEMSZ; a++) chk({tag, "_outside"}, int'(lbp_mem[a]), 'hAA, a);
    chk({tag, "_write_count"}, wr_cnt, 20, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gray_OE"}, int'(gray_OE), 0, 0);
    chk({tag, "_gray_addr"}, int'(gray_addr), 0, 0);
    chk({tag, "_lbp_WEN"}, int'(lbp_WEN), 0, 0);
    chk({tag, "_lbp_addr"}, int'(lbp_addr), 0, 0);
    chk({tag, "_lbp_data"}, int'(lbp_data), 0, 0);
    chk({tag, "_finish"}, int'(finish), 0, 0);
    chk({tag, "_busy"}, int'(busy), 0, 0);
  endtask

  task automatic set_thresh(input int t);
    th_val = t;
`ifdef LBP_THRESH_EN
    thresh = 8'(t);
`endif
  endtask

  int active;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    chk_on  = 1'b0;
    clr_mem = 1'b0;
    rst     = 1'b0;
    enable  = 1'b0;
    set_thresh(0);
    for (int i = 0; i < N; i++) img[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // constant 0x80: equal neighbours all satisfy >=
    for (int i = 0; i < N; i++) img[i] = 8'h80;
    chk("model_const", model_code(1, 1), 'hFF, 0);
    clear_mem();
    run_frame(2, -1);
    check_mem("const");
    chk("const_addr6", int'(lbp_mem[6]), 'hFF, 6);
    chk("const_addr13", int'(lbp_mem[13]), 'hFF, 13);
    chk("const_border0", int'(lbp_mem[0]), 'h00, 0);

    // ramp 10*r+c with an enable edge mid-frame (must be ignored)
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r * W + c] = 8'(10 * r + c);
    chk("model_ramp", model_code(1, 1), 'hF0, 0);
    clear_mem();
    run_frame(2, 10);
    check_mem("ramp");
    chk("ramp_addr6", int'(lbp_mem[6]), 'hF0, 6);

    // decreasing 100-(10*r+c): only the upper neighbours and left are >= centre
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r * W + c] = 8'(100 - (10 * r + c));
    chk("model_dec", model_code(1, 2), 'h0F, 0);
    clear_mem();
    run_frame(2, -1);
    check_mem("dec");
    chk("dec_addr7", int'(lbp_mem[7]), 'h0F, 7);

    // random coarse image with enable held high: exactly one frame
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 7) * 32);
    clear_mem();
    run_frame(-1, -1);
    check_mem("rand");
    active = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (finish || busy || gray_OE || lbp_WEN) active++;
    end
    chk("no_retrigger", active, 0, 0);
    enable = 1'b0;

    // reset mid-frame, enable kept high across reset, then a clean rerun
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
    clear_mem();
    build_expected();
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    cyc    = 0;
    chk_on = 1'b1;
    repeat (15) @(negedge clk);
    chk("midframe_busy", int'(busy), 1, 15);
    chk_on = 1'b0;
    rst = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    active = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy || gray_OE || lbp_WEN || finish) active++;
    end
    chk("no_start_without_edge", active, 0, 0);
    clear_mem();
    run_frame(2, -1);
    check_mem("rerun");

`ifdef LBP_THRESH_EN
    // thresh 0x10, centre 0x80: 0x8F misses, 0x90 hits -> odd bits
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
    img[6] = 8'h80;
    img[0] = 8'h8F; img[1] = 8'h90; img[2]  = 8'h8F; img[5]  = 8'h90;
    img[7] = 8'h8F; img[10] = 8'h90; img[11] = 8'h8F; img[12] = 8'h90;
    set_thresh('h10);
    chk("model_thresh", model_code(1, 1), 'hAA, 0);
    clear_mem();
    run_frame(2, -1);
    check_mem("thresh");
    chk("thresh_addr6", int'(lbp_mem[6]), 'hAA, 6);

    // thresh 0xFF, centre 0x01: reference overflows past any neighbour
    for (int i = 0; i < N; i++) img[i] = 8'h01;
    set_thresh('hFF);
    chk("model_ovf", model_code(1, 1), 'h00, 0);
    clear_mem();
    run_frame(2, -1);
    check_mem("ovf");
    chk("ovf_addr6", int'(lbp_mem[6]), 'h00, 6);
    set_thresh(0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
